// File: rtl/div_pkg.sv
// Shared types and helpers for the non-restoring divider.
// Build option: DIV_SIGNED_EN enables signed operation.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_MAX_W = 64;

  function automatic logic [DIV_MAX_W-1:0] DIV_ZERO_Q(
    input int w
  );
    logic [DIV_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < DIV_MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring iteration: shift, then add or subtract
// the divisor depending on the sign of the partial remainder.
module div_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] dx;

  assign sh     = {p[WIDTH-1:0], q_msb};
  assign dx     = {1'b0, d};
  assign p_next = p[WIDTH] ? sh + dx : sh - dx;
  assign q_bit  = ~p_next[WIDTH];

endmodule

// File: rtl/div_nr_param.sv
// Multi-cycle non-restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour sign_mode; otherwise unsigned only.
module div_nr_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] d;
  logic             neg_q;
  logic             neg_r;

  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   p_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] rem_u;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

`ifdef DIV_SIGNED_EN
  assign sgn = sign_mode;
`else
  logic unused_sign_mode;
  assign unused_sign_mode = sign_mode;
  assign sgn = 1'b0;
`endif

  assign a_mag = (sgn && dividend[WIDTH-1])
               ? -dividend : dividend;
  assign b_mag = (sgn && divisor[WIDTH-1])
               ? -divisor : divisor;

  div_nr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p),
    .q_msb  (qr[WIDTH-1]),
    .d      (d),
    .p_next (p_nxt),
    .q_bit  (q_bit)
  );

  // Final remainder lies in [0, d), so the add can wrap at WIDTH bits.
  assign rem_u = p[WIDTH] ? p[WIDTH-1:0] + d : p[WIDTH-1:0];
  assign q_out = neg_q ? -qr : qr;
  assign r_out = neg_r ? -rem_u : rem_u;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= '0;
      qr    <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            dz    <= 1'b0;
            cnt   <= '0;
            p     <= '0;
            d     <= b_mag;
            neg_q <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= sgn & dividend[WIDTH-1];
            if (divisor == '0) begin
              // Raw dividend is kept for r; FIX lingers one extra cycle.
              dz    <= 1'b1;
              qr    <= dividend;
              cnt   <= CNT_W'(1);
              state <= FIX;
            end else begin
              qr    <= a_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          p  <= p_nxt;
          qr <= {qr[WIDTH-2:0], q_bit};
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
            if (dz) begin
              q <= WIDTH'(DIV_ZERO_Q(WIDTH));
              r <= qr;
            end else begin
              q <= q_out;
              r <= r_out;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nr_param.sv
// Bench for div_nr_param: directed WIDTH=32 checks plus
// randomised WIDTH=8 runs against an arithmetic reference.
module tb_div_nr_param;

`ifdef DIV_SIGNED_EN
  localparam bit SGN_BUILD = 1'b1;
`else
  localparam bit SGN_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start32, sm32, busy32, done32, dz32;
  logic [31:0] a32, b32, q32, r32;
  logic        start8, sm8, busy8, done8, dz8;
  logic [7:0]  a8, b8, q8, r8;

  int n_tests = 0;
  int n_fail  = 0;

  div_nr_param #(.WIDTH(32)) dut32 (
    .clock     (clk),
    .reset     (rst_n),
    .start     (start32),
    .sign_mode (sm32),
    .dividend  (a32),
    .divisor   (b32),
    .q         (q32),
    .r         (r32),
    .busy      (busy32),
    .done      (done32),
    .dz        (dz32)
  );

  div_nr_param #(.WIDTH(8)) dut8 (
    .clock     (clk),
    .reset     (rst_n),
    .start     (start8),
    .sign_mode (sm8),
    .dividend  (a8),
    .divisor   (b8),
    .q         (q8),
    .r         (r8),
    .busy      (busy8),
    .done      (done8),
    .dz        (dz8)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truncating division on w-bit values with the spec's corner rules.
  function automatic void model(
    input  int          w,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  bit          s,
    output logic [31:0] q,
    output logic [31:0] r,
    output bit          z
  );
    longint av, bv, m;
    m = (longint'(1) << w) - 1;
    if (b == 0) begin
      q = 32'(m);
      r = a;
      z = 1'b1;
      return;
    end
    av = longint'(a);
    bv = longint'(b);
    if (s && SGN_BUILD && a[w-1]) av -= (longint'(1) << w);
    if (s && SGN_BUILD && b[w-1]) bv -= (longint'(1) << w);
    q = 32'((av / bv) & m);
    r = 32'((av % bv) & m);
    z = 1'b0;
  endfunction

  task automatic wait_idle32(output int n);
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic op32(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          s,
    input logic [31:0] eq,
    input logic [31:0] er,
    input bit          ez,
    input int          elat
  );
    int n;
    @(negedge clk);
    a32 = a; b32 = b; sm32 = s; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait_idle32(n);
    check({tag, ".lat"}, n, elat);
    check({tag, ".done"}, done32, 1);
    check({tag, ".q"}, q32, eq);
    check({tag, ".r"}, r32, er);
    check({tag, ".dz"}, dz32, ez);
  endtask

  task automatic op8(
    input logic [7:0] a,
    input logic [7:0] b,
    input bit         s
  );
    int n;
    logic [31:0] eq, er;
    bit ez;
    model(8, {24'd0, a}, {24'd0, b}, s, eq, er, ez);
    @(negedge clk);
    a8 = a; b8 = b; sm8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("w8.lat", n, (b == 0) ? 2 : 9);
    check("w8.done", done8, 1);
    check("w8.q", q8, eq[7:0]);
    check("w8.r", r8, er[7:0]);
    check("w8.dz", dz8, ez);
  endtask

  initial begin
    int n;
    start32 = 0; sm32 = 0; a32 = 0; b32 = 0;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst.busy", busy32, 0);
    check("rst.done", done32, 0);
    check("rst.q", q32, 0);
    check("rst.r", r32, 0);
    check("rst.dz", dz32, 0);
    rst_n = 1;

    op32("u100d7", 100, 7, 0, 14, 2, 0, 33);
    @(negedge clk);
    check("u100d7.pulse", done32, 0);
    op32("umax", 32'hFFFF_FFFF, 1, 0,
         32'hFFFF_FFFF, 0, 0, 33);
    op32("u5d0", 5, 0, 0, 32'hFFFF_FFFF, 5, 1, 2);

`ifdef DIV_SIGNED_EN
    op32("s-7d2", -32'sd7, 2, 1,
         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 33);
    op32("s7d-2", 7, -32'sd2, 1, 32'hFFFF_FFFD, 1, 0, 33);
    op32("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1,
         32'h8000_0000, 0, 0, 33);
    op32("s-5d0", -32'sd5, 0, 1,
         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 2);
    op32("sm0", 32'hFFFF_FFF9, 2, 0, 32'h7FFF_FFFC, 1, 0, 33);
`else
    op32("sm_ign", 32'hFFFF_FFF9, 2, 1,
         32'h7FFF_FFFC, 1, 0, 33);
`endif

    // start held high, operands churned while busy
    @(negedge clk);
    a32 = 100; b32 = 7; sm32 = 0; start32 = 1;
    @(negedge clk);
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      a32 = $urandom;
      b32 = $urandom;
      @(negedge clk);
    end
    check("hs.lat", n, 33);
    check("hs.done", done32, 1);
    check("hs.q", q32, 14);
    check("hs.r", r32, 2);
    a32 = 1000; b32 = 10;
    @(negedge clk);
    start32 = 0;
    wait_idle32(n);
    check("b2b.lat", n, 33);
    check("b2b.q", q32, 100);
    check("b2b.r", r32, 0);

    // reset during CALC iteration 10
    @(negedge clk);
    a32 = 100; b32 = 7; start32 = 1;
    @(negedge clk);
    start32 = 0;
    repeat (10) @(negedge clk);
    check("mid.busy", busy32, 1);
    #1 rst_n = 0;
    #1;
    check("mid.rst.busy", busy32, 0);
    check("mid.rst.done", done32, 0);
    check("mid.rst.q", q32, 0);
    check("mid.rst.r", r32, 0);
    @(negedge clk);
    rst_n = 1;
    op32("post_rst", 1000, 3, 0, 333, 1, 0, 33);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      if (i == 0) begin a = 8'h80; b = 8'hFF; end
      op8(a, b, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
